// File: rtl/timer_cmd_tx_if.sv
// Command/serial bundle between the timer command serializer and its environment.
// The slave side is the serializer; the master side is the command source plus the timer FSM.
interface timer_cmd_tx_if #(
    parameter int DELAY_W = 4
);
    logic               cmd_valid;
    logic [DELAY_W-1:0] cmd_delay;
    logic               cmd_ready;
    logic               data;
    logic               counting;
    logic               done;
    logic               ack;
    logic               busy;
    logic               err;

    modport master (
        output cmd_valid, cmd_delay, counting, done,
        input  cmd_ready, data, ack, busy, err
    );

    modport slave (
        input  cmd_valid, cmd_delay, counting, done,
        output cmd_ready, data, ack, busy, err
    );
endinterface

// File: rtl/timer_cmd_tx.sv
// Serializes {PREAMBLE, delay} MSB-first onto the timer's data line, waits for done,
// returns a one-cycle ack and enforces an idle gap before accepting the next command.
module timer_cmd_tx #(
    parameter logic [3:0] PREAMBLE = 4'b1101,
    parameter int         DELAY_W  = 4,
    parameter int         IDLE_GAP = 2,
    parameter int         TIMEOUT  = 20000
) (
    input  logic          clk,
    input  logic          reset,
    timer_cmd_tx_if.slave bus
);
    localparam int SH_W  = 4 + DELAY_W;
    localparam int BC_W  = $clog2(SH_W);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(IDLE_GAP + 1);

    localparam logic [BC_W-1:0]  LAST_BIT  = BC_W'(SH_W - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]  CNT_CHECK = TO_W'(3);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(IDLE_GAP - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        WAIT_DONE = 3'd2,
        ACK       = 3'd3,
        GAP       = 3'd4
    } state_t;

    state_t            state_r;
    logic [SH_W-1:0]   shift_r;
    logic [BC_W-1:0]   bit_cnt_r;
    logic [TO_W-1:0]   to_cnt_r;
    logic [GAP_W-1:0]  gap_cnt_r;
    logic              data_r;
    logic              ack_r;
    logic              err_r;
    logic              busy_r;
    logic              cmd_ready_r;

    assign bus.data      = data_r;
    assign bus.ack       = ack_r;
    assign bus.err       = err_r;
    assign bus.busy      = busy_r;
    assign bus.cmd_ready = cmd_ready_r;

    // Control FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            shift_r     <= '0;
            bit_cnt_r   <= '0;
            to_cnt_r    <= '0;
            gap_cnt_r   <= '0;
            data_r      <= 1'b0;
            ack_r       <= 1'b0;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
            cmd_ready_r <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_r) begin
                        // Preamble MSB goes out immediately; shift_r holds the remaining bits.
                        data_r      <= PREAMBLE[3];
                        shift_r     <= {PREAMBLE[2:0], bus.cmd_delay, 1'b0};
                        bit_cnt_r   <= '0;
                        err_r       <= 1'b0;
                        busy_r      <= 1'b1;
                        cmd_ready_r <= 1'b0;
                        state_r     <= SEND;
                    end else begin
                        data_r <= 1'b0;
                    end
                end
                SEND: begin
                    if (bit_cnt_r == LAST_BIT) begin
                        data_r   <= 1'b0;
                        to_cnt_r <= '0;
                        state_r  <= WAIT_DONE;
                    end else begin
                        data_r    <= shift_r[SH_W-1];
                        shift_r   <= {shift_r[SH_W-2:0], 1'b0};
                        bit_cnt_r <= bit_cnt_r + BC_W'(1);
                    end
                end
                WAIT_DONE: begin
                    data_r <= 1'b0;
                    // done is checked first so it beats a coincident terminal count.
                    if (bus.done) begin
                        ack_r   <= 1'b1;
                        state_r <= ACK;
                    end else if ((to_cnt_r == TO_LAST) ||
                                 ((to_cnt_r == CNT_CHECK) && !bus.counting)) begin
                        err_r     <= 1'b1;
                        gap_cnt_r <= '0;
                        state_r   <= GAP;
                    end else begin
                        // Only reached below TO_LAST, so the counter cannot wrap.
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                end
                ACK: begin
                    data_r    <= 1'b0;
                    ack_r     <= 1'b0;
                    gap_cnt_r <= '0;
                    state_r   <= GAP;
                end
                GAP: begin
                    data_r <= 1'b0;
                    if (gap_cnt_r == GAP_LAST) begin
                        busy_r      <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                    end
                end
                default: begin
                    data_r      <= 1'b0;
                    ack_r       <= 1'b0;
                    busy_r      <= 1'b0;
                    cmd_ready_r <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end
endmodule
